// File: rtl/adder_arbiter.sv
// Round-robin front end that time-shares a single valid/ready adder between
// NUM_REQ requesters; one operation in flight, result routed back by ID.

module adder_arbiter_lane (
  input  logic grant_i,
  input  logic idle_i,
  input  logic resp_i,
  input  logic own_i,
  input  logic rsp_ready_i,
  output logic req_ready_o,
  output logic rsp_valid_o,
  output logic rsp_done_o
);
  assign req_ready_o = idle_i & grant_i;
  assign rsp_valid_o = resp_i & own_i;
  assign rsp_done_o  = rsp_valid_o & rsp_ready_i;
endmodule

module adder_arbiter #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int NUM_REQ       = 4
) (
  input  logic                             clk_i,
  input  logic                             arst_n,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic [DATA_IN_WIDTH:0]           rsp_sum_o,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [DATA_IN_WIDTH-1:0]         add_a_o,
  output logic                             add_a_valid_o,
  input  logic                             add_a_ready_i,
  output logic [DATA_IN_WIDTH-1:0]         add_b_o,
  output logic                             add_b_valid_o,
  input  logic                             add_b_ready_i,
  input  logic [DATA_IN_WIDTH:0]           add_sum_i,
  input  logic                             add_sum_valid_i,
  output logic                             add_sum_ready_o,
  output logic                             busy_o
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                                  state_q, state_d;
  logic [ID_W-1:0]                         rr_q, rr_d;
  logic [ID_W-1:0]                         id_q, id_d;
  logic [DATA_IN_WIDTH-1:0]                a_q, a_d, b_q, b_d;
  logic [DATA_IN_WIDTH:0]                  sum_q, sum_d;

  logic [NUM_REQ-1:0][DATA_IN_WIDTH-1:0]   a_arr, b_arr;
  logic [NUM_REQ-1:0]                      gnt_oh, own_oh, rsp_done;
  logic                                    gnt_found;
  logic [ID_W-1:0]                         gnt_id;
  logic [ID_W-1:0]                         scan_id;
  int                                      scan;
  logic                                    add_fire;

  assign a_arr = req_a_i;
  assign b_arr = req_b_i;

  // Scan from rr_q upward, wrapping; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan      = 0;
    scan_id   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      scan_id = ID_W'(scan);
      if (!gnt_found && req_valid_i[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
    end
  end

  always_comb begin
    gnt_oh         = '0;
    own_oh         = '0;
    gnt_oh[gnt_id] = gnt_found;
    own_oh[id_q]   = 1'b1;
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    adder_arbiter_lane u_lane (
      .grant_i     (gnt_oh[i]),
      .idle_i      (state_q == IDLE),
      .resp_i      (state_q == RESP),
      .own_i       (own_oh[i]),
      .rsp_ready_i (rsp_ready_i[i]),
      .req_ready_o (req_ready_o[i]),
      .rsp_valid_o (rsp_valid_o[i]),
      .rsp_done_o  (rsp_done[i])
    );
  end

  assign add_fire = add_sum_valid_i & add_a_ready_i & add_b_ready_i;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          a_d     = a_arr[gnt_id];
          b_d     = b_arr[gnt_id];
          id_d    = gnt_id;
          rr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (add_fire) begin
          sum_d   = add_sum_i;
          state_d = RESP;
        end
      end
      RESP: begin
        // Only the owner's rsp_ready can retire the result.
        if (|rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign add_a_valid_o   = (state_q == ISSUE);
  assign add_b_valid_o   = (state_q == ISSUE);
  assign add_sum_ready_o = (state_q == ISSUE);
  assign add_a_o         = (state_q == ISSUE) ? a_q : '0;
  assign add_b_o         = (state_q == ISSUE) ? b_q : '0;
  assign rsp_sum_o       = sum_q;
  assign busy_o          = (state_q != IDLE);
endmodule
